// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_cmd_ctrl: parses {HEADER,ADDR,DATA,CHK} UART frames into four 8-bit control registers.
// Revision: 1.0
// ----------------------------------------------------------------------------
module uart_cmd_ctrl #(
  parameter logic [7:0] HEADER      = 8'hAA,
  parameter int         TIMEOUT_CYC = 520700,
  parameter int         TO_W        = 20
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        rx_idle,
  input  logic [7:0]  rx_data,
  output logic [31:0] ctrl_reg,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_CHK  = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ERR_CHK  = 2'b01;
  localparam logic [1:0] ERR_ADDR = 2'b10;
  localparam logic [1:0] ERR_TO   = 2'b11;

  state_t            state_q,     state_d;
  logic              rx_idle_q,   rx_idle_d;
  logic [7:0]        addr_q,      addr_d;
  logic [7:0]        data_q,      data_d;
  logic [TO_W-1:0]   to_cnt_q,    to_cnt_d;
  logic [31:0]       ctrl_reg_q,  ctrl_reg_d;
  logic              frame_ok_q,  frame_ok_d;
  logic              frame_err_q, frame_err_d;
  logic [1:0]        err_code_q,  err_code_d;
  logic              busy_q,      busy_d;

  logic              byte_stb;
  logic              to_hit;

  assign byte_stb = rx_idle & ~rx_idle_q;
  assign to_hit   = (to_cnt_q == TO_LAST);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rx_idle_q   <= 1'b1;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      to_cnt_q    <= '0;
      ctrl_reg_q  <= 32'h0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_idle_q   <= rx_idle_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      to_cnt_q    <= to_cnt_d;
      ctrl_reg_q  <= ctrl_reg_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rx_idle_d   = rx_idle;
    addr_d      = addr_q;
    data_d      = data_q;
    ctrl_reg_d  = ctrl_reg_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;

    if (state_q == ST_IDLE || byte_stb) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (byte_stb && rx_data == HEADER) begin
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (byte_stb) begin
          addr_d  = rx_data;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (byte_stb) begin
          data_d  = rx_data;
          state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (byte_stb) begin
          state_d = ST_IDLE;
          // Checksum is judged before the address so it wins when both are wrong.
          if (rx_data != (addr_q ^ data_q)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
          end else if (addr_q[7:2] != 6'd0) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_ADDR;
          end else begin
            ctrl_reg_d[{addr_q[1:0], 3'b000} +: 8] = data_q;
            frame_ok_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A byte arriving on the terminal-count cycle is accepted instead of timing out.
    if (state_q != ST_IDLE && !byte_stb && to_hit) begin
      state_d     = ST_IDLE;
      to_cnt_d    = '0;
      frame_err_d = 1'b1;
      err_code_d  = ERR_TO;
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign ctrl_reg  = ctrl_reg_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
